// File: rtl/jtag_modport_slave.sv
// jtag_modport_slave: IEEE 1149.1-style TAP slave with a 16-state TAP
// controller, an instruction register and three data registers (BYPASS,
// IDCODE and a JTAG read/write USER configuration word).
module jtag_modport_slave #(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h4A11_0E3F,
  parameter int          USER_W     = 32
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              POWER_OK,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic [USER_W-1:0] user_data,
  output logic [IR_W-1:0]   ir_value
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_t;

  localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(4'b0001);
  localparam logic [IR_W-1:0] IR_USER    = IR_W'(4'b0010);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(4'b0101);

  tap_state_t        state;
  tap_state_t        next_state;
  logic              rst_n;
  logic              sel_idcode;
  logic              sel_user;
  logic [IR_W-1:0]   ir_sr;
  logic              bypass_sr;
  logic [31:0]       idcode_sr;
  logic [USER_W-1:0] user_sr;

  // A power-fail indication is treated exactly like a TAP reset.
  assign rst_n = trst & POWER_OK;

  // Any code other than IDCODE or USER falls back to BYPASS.
  assign sel_idcode = (ir_value == IR_IDCODE);
  assign sel_user   = (ir_value == IR_USER);

  // TAP controller state register.
  always_ff @(posedge tck) begin
    if (!rst_n) state <= TLR;
    else        state <= next_state;
  end

  // Standard 1149.1 next-state decode on tms.
  always_comb begin
    next_state = state;
    unique case (state)
      TLR:    next_state = tms ? TLR    : RTI;
      RTI:    next_state = tms ? SEL_DR : RTI;
      SEL_DR: next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR: next_state = tms ? EX1_DR : SH_DR;
      SH_DR:  next_state = tms ? EX1_DR : SH_DR;
      EX1_DR: next_state = tms ? UPD_DR : PA_DR;
      PA_DR:  next_state = tms ? EX2_DR : PA_DR;
      EX2_DR: next_state = tms ? UPD_DR : SH_DR;
      UPD_DR: next_state = tms ? SEL_DR : RTI;
      SEL_IR: next_state = tms ? TLR    : CAP_IR;
      CAP_IR: next_state = tms ? EX1_IR : SH_IR;
      SH_IR:  next_state = tms ? EX1_IR : SH_IR;
      EX1_IR: next_state = tms ? UPD_IR : PA_IR;
      PA_IR:  next_state = tms ? EX2_IR : PA_IR;
      EX2_IR: next_state = tms ? UPD_IR : SH_IR;
      UPD_IR: next_state = tms ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  // Instruction register: capture, shift, update; forced to IDCODE on entering or sitting in TLR.
  always_ff @(posedge tck) begin
    if (!rst_n) begin
      ir_sr    <= '0;
      ir_value <= IR_IDCODE;
    end else begin
      unique case (state)
        CAP_IR:  ir_sr    <= IR_CAPTURE;
        SH_IR:   ir_sr    <= {tdi, ir_sr[IR_W-1:1]};
        UPD_IR:  ir_value <= ir_sr;
        default: ;
      endcase
      if (next_state == TLR) ir_value <= IR_IDCODE;
    end
  end

  // Data registers: only the register selected by the current instruction captures or shifts; pause states hold.
  always_ff @(posedge tck) begin
    if (!rst_n) begin
      bypass_sr <= 1'b0;
      idcode_sr <= '0;
      user_sr   <= '0;
      user_data <= '0;
    end else begin
      unique case (state)
        CAP_DR: begin
          if (sel_user)        user_sr   <= user_data;
          else if (sel_idcode) idcode_sr <= IDCODE_VAL;
          else                 bypass_sr <= 1'b0;
        end
        SH_DR: begin
          if (sel_user)        user_sr   <= {tdi, user_sr[USER_W-1:1]};
          else if (sel_idcode) idcode_sr <= {tdi, idcode_sr[31:1]};
          else                 bypass_sr <= tdi;
        end
        UPD_DR: begin
          if (sel_user) user_data <= user_sr;
        end
        default: ;
      endcase
    end
  end

  // tdo presents the LSB about to be shifted out so a rising-edge sampler sees it first.
  always_comb begin
    tdo = 1'b0;
    if (state == SH_DR) begin
      if (sel_user)        tdo = user_sr[0];
      else if (sel_idcode) tdo = idcode_sr[0];
      else                 tdo = bypass_sr;
    end else if (state == SH_IR) begin
      tdo = ir_sr[0];
    end
  end

endmodule

// File: tb/tb_jtag_modport_slave.sv
// tb_jtag_modport_slave: directed scans through the TAP slave with
// hand-computed expected values.
module tb_jtag_modport_slave;

  logic        tck;
  logic        trst;
  logic        POWER_OK;
  logic        tms;
  logic        tdi;
  logic        tdo;
  logic [31:0] user_data;
  logic [3:0]  ir_value;

  int checks;
  int errors;

  jtag_modport_slave dut (
    .tck       (tck),
    .trst      (trst),
    .POWER_OK  (POWER_OK),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .user_data (user_data),
    .ir_value  (ir_value)
  );

  // Free-running tck; stimulus changes and observation happen on the falling edge.
  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  task automatic step(input logic tms_v, input logic tdi_v, output logic tdo_o);
    tdo_o = tdo;
    tms   = tms_v;
    tdi   = tdi_v;
    @(negedge tck);
  endtask

  task automatic go(input logic tms_v);
    logic d;
    step(tms_v, 1'b0, d);
  endtask

  // From RTI: full IR scan of 4 bits, back to RTI.
  task automatic scan_ir(input logic [3:0] din, output logic [3:0] dout);
    logic b;
    dout = '0;
    go(1'b1); go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, din[i], b);
      dout[i] = b;
    end
    go(1'b1); go(1'b0);
  endtask

  // From RTI: DR scan of n bits, back to RTI.
  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic b;
    dout = '0;
    go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], b);
      dout[i] = b;
    end
    go(1'b1); go(1'b0);
  endtask

  task automatic test_reset();
    trst = 1'b0;
    go(1'b1); go(1'b0);
    checks++;
    if (ir_value !== 4'b0001) begin errors++; $display("[TB] FAIL reset_ir: got %h expected %h", ir_value, 4'b0001); end
    checks++;
    if (user_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_user: got %h expected %h", user_data, 32'h0); end
    checks++;
    if (tdo !== 1'b0) begin errors++; $display("[TB] FAIL reset_tdo: got %b expected 0", tdo); end
    trst = 1'b1;
    go(1'b1);
    go(1'b0);
  endtask

  task automatic test_idcode();
    logic [31:0] d;
    scan_dr(32'h0, 32, d);
    checks++;
    if (d !== 32'h4A11_0E3F) begin errors++; $display("[TB] FAIL idcode_scan: got %h expected %h", d, 32'h4A11_0E3F); end
  endtask

  task automatic test_bypass();
    logic [3:0]  ir_out;
    logic [31:0] d;
    scan_ir(4'b1111, ir_out);
    checks++;
    if (ir_out !== 4'b0101) begin errors++; $display("[TB] FAIL ir_capture: got %b expected %b", ir_out, 4'b0101); end
    checks++;
    if (ir_value !== 4'b1111) begin errors++; $display("[TB] FAIL ir_bypass: got %h expected %h", ir_value, 4'hF); end
    scan_dr(32'h0000_00A5, 8, d);
    checks++;
    if (d !== 32'h0000_004A) begin errors++; $display("[TB] FAIL bypass_a5: got %h expected %h", d, 32'h4A); end
    // An undefined code also behaves as BYPASS.
    scan_ir(4'b0110, ir_out);
    checks++;
    if (ir_out !== 4'b0101) begin errors++; $display("[TB] FAIL ir_capture2: got %b expected %b", ir_out, 4'b0101); end
    checks++;
    if (ir_value !== 4'b0110) begin errors++; $display("[TB] FAIL ir_undef: got %h expected %h", ir_value, 4'h6); end
    scan_dr(32'h0000_003C, 8, d);
    checks++;
    if (d !== 32'h0000_0078) begin errors++; $display("[TB] FAIL bypass_undef: got %h expected %h", d, 32'h78); end
  endtask

  task automatic test_user();
    logic [3:0]  ir_out;
    logic [31:0] d;
    scan_ir(4'b0010, ir_out);
    checks++;
    if (ir_value !== 4'b0010) begin errors++; $display("[TB] FAIL ir_user: got %h expected %h", ir_value, 4'h2); end
    scan_dr(32'hDEAD_BEEF, 32, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL user_first_read: got %h expected %h", d, 32'h0); end
    checks++;
    if (user_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL user_write: got %h expected %h", user_data, 32'hDEAD_BEEF); end
    scan_dr(32'hDEAD_BEEF, 32, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL user_readback: got %h expected %h", d, 32'hDEAD_BEEF); end
  endtask

  task automatic test_tlr_escape();
    logic        b;
    logic [4:0]  got;
    logic [31:0] d;
    // Five ones from RTI reach TLR and restore IDCODE.
    for (int i = 0; i < 5; i++) go(1'b1);
    checks++;
    if (ir_value !== 4'b0001) begin errors++; $display("[TB] FAIL tlr_from_rti_ir: got %h expected %h", ir_value, 4'h1); end
    go(1'b0);
    // Enter SH_DR under IDCODE and shift 5 bits, then escape mid-scan.
    go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, b);
      got[i] = b;
    end
    checks++;
    if (got !== 5'b11111) begin errors++; $display("[TB] FAIL idcode_low_bits: got %b expected %b", got, 5'b11111); end
    for (int i = 0; i < 5; i++) go(1'b1);
    checks++;
    if (ir_value !== 4'b0001) begin errors++; $display("[TB] FAIL tlr_escape_ir: got %h expected %h", ir_value, 4'h1); end
    checks++;
    if (user_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL tlr_escape_user: got %h expected %h", user_data, 32'hDEAD_BEEF); end
    checks++;
    if (tdo !== 1'b0) begin errors++; $display("[TB] FAIL tlr_escape_tdo: got %b expected 0", tdo); end
    // From TLR one tms=0 edge reaches RTI; a DR scan then reads IDCODE from scratch.
    go(1'b0);
    scan_dr(32'h0, 32, d);
    checks++;
    if (d !== 32'h4A11_0E3F) begin errors++; $display("[TB] FAIL idcode_after_tlr: got %h expected %h", d, 32'h4A11_0E3F); end
  endtask

  task automatic test_async_abort();
    logic [3:0]  ir_out;
    logic [31:0] d;
    // trst in the middle of a USER scan.
    scan_ir(4'b0010, ir_out);
    go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < 10; i++) go(1'b0);
    trst = 1'b0;
    go(1'b0);
    trst = 1'b1;
    checks++;
    if (user_data !== 32'h0) begin errors++; $display("[TB] FAIL trst_user: got %h expected %h", user_data, 32'h0); end
    checks++;
    if (ir_value !== 4'b0001) begin errors++; $display("[TB] FAIL trst_ir: got %h expected %h", ir_value, 4'h1); end
    checks++;
    if (tdo !== 1'b0) begin errors++; $display("[TB] FAIL trst_tdo: got %b expected 0", tdo); end
    // POWER_OK low behaves the same.
    go(1'b0);
    scan_ir(4'b0010, ir_out);
    scan_dr(32'h0F0F_1234, 32, d);
    checks++;
    if (user_data !== 32'h0F0F_1234) begin errors++; $display("[TB] FAIL pok_setup: got %h expected %h", user_data, 32'h0F0F_1234); end
    go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < 7; i++) go(1'b0);
    POWER_OK = 1'b0;
    go(1'b0);
    POWER_OK = 1'b1;
    checks++;
    if (user_data !== 32'h0) begin errors++; $display("[TB] FAIL pok_user: got %h expected %h", user_data, 32'h0); end
    checks++;
    if (ir_value !== 4'b0001) begin errors++; $display("[TB] FAIL pok_ir: got %h expected %h", ir_value, 4'h1); end
    checks++;
    if (tdo !== 1'b0) begin errors++; $display("[TB] FAIL pok_tdo: got %b expected 0", tdo); end
    go(1'b0);
  endtask

  task automatic test_pause();
    logic [3:0]  ir_out;
    logic [31:0] d;
    logic [31:0] dout;
    logic [31:0] din;
    logic        b;
    logic        p;
    din = 32'h1357_9BDF;
    scan_ir(4'b0010, ir_out);
    scan_dr(32'hA5A5_5A5A, 32, d);
    dout = '0;
    go(1'b1); go(1'b0); go(1'b0);
    for (int i = 0; i < 10; i++) begin
      step(i == 9, din[i], b);
      dout[i] = b;
    end
    go(1'b0);
    step(1'b0, 1'b1, p);
    checks++;
    if (p !== 1'b0) begin errors++; $display("[TB] FAIL pause_tdo: got %b expected 0", p); end
    go(1'b0);
    go(1'b1);
    go(1'b0);
    for (int i = 10; i < 32; i++) begin
      step(i == 31, din[i], b);
      dout[i] = b;
    end
    go(1'b1); go(1'b0);
    checks++;
    if (dout !== 32'hA5A5_5A5A) begin errors++; $display("[TB] FAIL pause_readout: got %h expected %h", dout, 32'hA5A5_5A5A); end
    checks++;
    if (user_data !== 32'h1357_9BDF) begin errors++; $display("[TB] FAIL pause_write: got %h expected %h", user_data, 32'h1357_9BDF); end
  endtask

  // Test sequence.
  initial begin
    checks   = 0;
    errors   = 0;
    trst     = 1'b0;
    POWER_OK = 1'b1;
    tms      = 1'b1;
    tdi      = 1'b0;
    @(negedge tck);
    test_reset();
    test_idcode();
    test_bypass();
    test_user();
    test_tlr_escape();
    test_async_abort();
    test_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
